// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: registered fetch with req/valid handshake, program-load
// write port, and a power-on sequencer that fills every word with NOP_WORD before use.
module instr_mem_sync #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              init_done
);

  // state | meaning
  // CLEAR | writing NOP_WORD to mem[clr_cnt], one word per cycle; fetch/load blocked
  // RUN   | normal operation; terminal until reset
  typedef enum logic {CLEAR, RUN} state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_accept;
  logic              misaligned;
  logic [ADDR_W-1:0] word_idx;

  assign load_ready   = (state == RUN);
  assign fetch_ready  = (state == RUN) && !load_we;
  assign init_done    = (state == RUN);
  assign fetch_accept = fetch_req && fetch_ready;
  assign misaligned   = |fetch_addr[1:0];
  assign word_idx     = fetch_addr[ADDR_W+1:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Clear and load share one write port; the two never overlap because load is gated on RUN.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    mem_we       = 1'b0;
    mem_addr     = load_addr;
    mem_wdata    = load_data;
    case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = clr_cnt;
        mem_wdata    = NOP_WORD;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) state_next = RUN;
      end
      RUN: begin
        mem_we = load_we;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_err  <= misaligned;
        fetch_data <= misaligned ? NOP_WORD : mem[word_idx];
      end
    end
  end

endmodule
